// File: rtl/ifetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_pkg
//  Description : Shared types and constants for the instruction fetch unit:
//                FSM state encoding, opcode field position and opcode values,
//                plus a saturating-increment helper for the perf counters.
//  Revision    : 1.0  initial release
// ============================================================================
package ifetch_pkg;

    // Fetch FSM states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_HOLD    = 2'd2,
        ST_DISCARD = 2'd3
    } ifetch_state_e;

    // Opcode field, as bit offsets below the instruction MSB, so the field
    // stays in the top two bits whatever INSTR_W is.
    localparam int OPCODE_HI = 0;
    localparam int OPCODE_LO = 1;

    // Opcode values seen by the control unit
    localparam logic [1:0] OP_ALU  = 2'b00;
    localparam logic [1:0] OP_ALUI = 2'b01;
    localparam logic [1:0] OP_BR   = 2'b10;
    localparam logic [1:0] OP_BRI  = 2'b11;

    // Increment that sticks at all-ones
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage : ifetch_pkg
`default_nettype wire

// File: rtl/ifetch_perf_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_perf_cnt
//  Description : Pair of 16-bit saturating event counters: accepted decode
//                handshakes and decode back-pressure (stall) cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module ifetch_perf_cnt
    import ifetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_inc,
    input  logic        stall_inc,
    output logic [15:0] perf_fetch_cnt,
    output logic [15:0] perf_stall_cnt
);

    logic [15:0] r_fetch_cnt;
    logic [15:0] r_stall_cnt;

    // Count events, holding at 16'hFFFF once reached
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_cnt <= 16'd0;
            r_stall_cnt <= 16'd0;
        end else begin
            if (fetch_inc) r_fetch_cnt <= sat_inc16(r_fetch_cnt);
            if (stall_inc) r_stall_cnt <= sat_inc16(r_stall_cnt);
        end
    end

    assign perf_fetch_cnt = r_fetch_cnt;
    assign perf_stall_cnt = r_stall_cnt;

endmodule : ifetch_perf_cnt
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Instruction fetch front end. Issues one request at a time to
//                instruction memory (req/ack), buffers the returned word in a
//                single-entry output register offered to decode (valid/ready)
//                and follows taken-branch redirects from execute. A redirect
//                that lands while a request is in flight parks the FSM in
//                DISCARD until that stale ack has been absorbed.
//                Optional macro IFETCH_PERF_EN adds handshake/stall counters.
//  Revision    : 1.0  initial release
// ============================================================================
module instr_fetch_unit
    import ifetch_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter int              INSTR_W  = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    output logic [1:0]         opcode,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc
`ifdef IFETCH_PERF_EN
    ,
    output logic [15:0]        perf_fetch_cnt,
    output logic [15:0]        perf_stall_cnt
`endif
);

    localparam logic [PC_W-1:0] c_pc_one = PC_W'(1);

    ifetch_state_e      r_state;
    ifetch_state_e      w_state_nxt;
    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    w_pc_nxt;
    logic               r_imem_req;
    logic               w_imem_req_nxt;
    logic [PC_W-1:0]    r_imem_addr;
    logic [PC_W-1:0]    w_imem_addr_nxt;
    logic               r_instr_valid;
    logic               w_instr_valid_nxt;
    logic [INSTR_W-1:0] r_instr;
    logic [INSTR_W-1:0] w_instr_nxt;
    logic [PC_W-1:0]    r_instr_pc;
    logic [PC_W-1:0]    w_instr_pc_nxt;

    logic               w_handshake;
    logic [PC_W-1:0]    w_pc_inc;

    assign w_handshake = r_instr_valid & instr_ready;
    assign w_pc_inc    = r_pc + c_pc_one;   // wraps modulo 2^PC_W

    // State and output registers; reset returns to IDLE and drops the request
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_pc          <= RESET_PC;
            r_imem_req    <= 1'b0;
            r_imem_addr   <= RESET_PC;
            r_instr_valid <= 1'b0;
            r_instr       <= '0;
            r_instr_pc    <= RESET_PC;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_imem_req    <= w_imem_req_nxt;
            r_imem_addr   <= w_imem_addr_nxt;
            r_instr_valid <= w_instr_valid_nxt;
            r_instr       <= w_instr_nxt;
            r_instr_pc    <= w_instr_pc_nxt;
        end
    end

    // Next-state and next-output logic; redirect outranks every other event
    // except in IDLE, where both redirects and acks are ignored.
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_imem_addr_nxt   = r_imem_addr;
        w_instr_valid_nxt = r_instr_valid;
        w_instr_nxt       = r_instr;
        w_instr_pc_nxt    = r_instr_pc;

        case (r_state)
            ST_IDLE: begin
                w_state_nxt     = ST_REQ;
                w_imem_addr_nxt = r_pc;
            end

            ST_REQ: begin
                if (redirect) begin
                    w_pc_nxt = redirect_pc;
                    if (imem_ack) begin
                        // Returned word belongs to the wrong path: drop it
                        w_state_nxt     = ST_REQ;
                        w_imem_addr_nxt = redirect_pc;
                    end else begin
                        // Request still in flight: keep its address until ack
                        w_state_nxt = ST_DISCARD;
                    end
                end else if (imem_ack) begin
                    w_instr_nxt       = imem_rdata;
                    w_instr_pc_nxt    = r_imem_addr;
                    w_instr_valid_nxt = 1'b1;
                    w_state_nxt       = ST_HOLD;
                end
            end

            ST_HOLD: begin
                if (redirect) begin
                    // A simultaneous handshake is consumed but pc+1 is not taken
                    w_instr_valid_nxt = 1'b0;
                    w_pc_nxt          = redirect_pc;
                    w_imem_addr_nxt   = redirect_pc;
                    w_state_nxt       = ST_REQ;
                end else if (w_handshake) begin
                    w_instr_valid_nxt = 1'b0;
                    w_pc_nxt          = w_pc_inc;
                    w_imem_addr_nxt   = w_pc_inc;
                    w_state_nxt       = ST_REQ;
                end
            end

            ST_DISCARD: begin
                if (redirect) begin
                    w_pc_nxt = redirect_pc;
                    if (imem_ack) begin
                        w_state_nxt     = ST_REQ;
                        w_imem_addr_nxt = redirect_pc;
                    end
                end else if (imem_ack) begin
                    w_state_nxt     = ST_REQ;
                    w_imem_addr_nxt = r_pc;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Request is asserted exactly while a fetch is outstanding
        w_imem_req_nxt = (w_state_nxt == ST_REQ) || (w_state_nxt == ST_DISCARD);
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_imem_addr;
    assign instr_valid = r_instr_valid;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign opcode      = r_instr[INSTR_W-1-OPCODE_HI : INSTR_W-1-OPCODE_LO];

`ifdef IFETCH_PERF_EN
    logic w_stall;

    assign w_stall = r_instr_valid & ~instr_ready;

    ifetch_perf_cnt u_perf_cnt (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_inc      (w_handshake),
        .stall_inc      (w_stall),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
    );
`endif

endmodule : instr_fetch_unit
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_unit
//  Description : Self-checking bench for instr_fetch_unit. A memory model
//                answers requests after 1..3 cycles; a transaction-level
//                reference tracks which address decode must see next.
//                Directed scenarios first, then randomized traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam int         PC_W     = 8;
    localparam int         INSTR_W  = 8;
    localparam logic [7:0] RESET_PC = 8'h10;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack = 1'b0;
    logic [INSTR_W-1:0] imem_rdata = '0;
    logic               instr_valid;
    logic               instr_ready = 1'b0;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    instr_pc;
    logic [1:0]         opcode;
    logic               redirect = 1'b0;
    logic [PC_W-1:0]    redirect_pc = '0;
`ifdef IFETCH_PERF_EN
    logic [15:0]        perf_fetch_cnt;
    logic [15:0]        perf_stall_cnt;
`endif

    instr_fetch_unit #(
        .PC_W     (PC_W),
        .INSTR_W  (INSTR_W),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .opcode         (opcode),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Instruction memory: fixed random contents, ack 1..3 cycles after the
    // request is first seen; an accepted request completes even if the
    // requester is reset meanwhile.
    // ------------------------------------------------------------------
    logic [7:0] mem [256];
    int         force_dly = 0;
    bit         mem_busy  = 1'b0;
    int         mem_cnt   = 0;
    logic [7:0] mem_addr_l = '0;

    always @(negedge clk) begin
        if (imem_ack) begin
            imem_ack = 1'b0;
            mem_busy = 1'b0;
        end
        if (!mem_busy && imem_req === 1'b1) begin
            mem_busy   = 1'b1;
            mem_cnt    = (force_dly > 0) ? force_dly : int'($urandom_range(1, 3));
            mem_addr_l = imem_addr;
        end else if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) imem_ack = 1'b1;
        end
        imem_rdata = imem_ack ? mem[mem_addr_l] : 8'($urandom);
    end

    // ------------------------------------------------------------------
    // Reference model, evaluated mid-cycle once inputs are settled.
    // m_pc      : address of the instruction decode must see next
    // m_stale   : the in-flight request was overtaken by a redirect
    // m_idle    : first cycle after reset (acks/redirects ignored)
    // ------------------------------------------------------------------
    logic [7:0] m_pc = '0;
    bit         m_stale = 1'b0;
    bit         m_idle = 1'b0;
    bit         m_exp_valid = 1'b0;
    int         m_fetch = 0;
    int         m_stall = 0;
    bit         mon_en = 1'b0;

    bit         p_valid = 1'b0, p_ready = 1'b0, p_redir = 1'b0, p_rstn = 1'b0;
    bit         p_req = 1'b0, p_ack = 1'b0;
    logic [7:0] p_instr = '0, p_ipc = '0, p_addr = '0;

    always @(negedge clk) begin
        #2;
        if (mon_en) begin
            check("valid", instr_valid, m_exp_valid);
            if (instr_valid) begin
                check("instr_pc", instr_pc, m_pc);
                check("instr", instr, mem[m_pc]);
                check("opcode", opcode, mem[m_pc][7:6]);
                check("no_req_in_hold", imem_req, 1'b0);
            end
            if (imem_req && !m_stale && !m_idle)
                check("fetch_addr", imem_addr, m_pc);
            if (p_rstn && p_req && !p_ack)
                check("addr_stable", imem_addr, p_addr);
            if (p_rstn && p_valid && !p_ready && !p_redir) begin
                check("instr_stable", instr, p_instr);
                check("instr_pc_stable", instr_pc, p_ipc);
            end
`ifdef IFETCH_PERF_EN
            check("perf_fetch", perf_fetch_cnt, m_fetch);
            check("perf_stall", perf_stall_cnt, m_stall);
`endif
        end

        if (!rst_n) begin
            m_pc        = RESET_PC;
            m_stale     = 1'b0;
            m_idle      = 1'b1;
            m_exp_valid = 1'b0;
            m_fetch     = 0;
            m_stall     = 0;
        end else begin
            if (instr_valid && !instr_ready && m_stall < 16'hFFFF) m_stall++;
            if (instr_valid && instr_ready && m_fetch < 16'hFFFF) m_fetch++;
            if (m_idle) begin
                m_idle      = 1'b0;
                m_exp_valid = 1'b0;
            end else if (redirect) begin
                m_stale     = imem_req && !imem_ack;
                m_pc        = redirect_pc;
                m_exp_valid = 1'b0;
            end else begin
                m_exp_valid = instr_valid && !instr_ready;
                if (imem_req && imem_ack) begin
                    if (m_stale) m_stale = 1'b0;
                    else         m_exp_valid = 1'b1;
                end
                if (instr_valid && instr_ready) m_pc = m_pc + 8'd1;
            end
        end

        p_valid = instr_valid;
        p_ready = instr_ready;
        p_redir = redirect;
        p_rstn  = rst_n;
        p_req   = imem_req;
        p_ack   = imem_ack;
        p_instr = instr;
        p_ipc   = instr_pc;
        p_addr  = imem_addr;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 time unit after the falling edge
    // ------------------------------------------------------------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!instr_valid && n < budget) begin
            step();
            n++;
        end
        check("wait_valid_timeout", instr_valid, 1'b1);
    endtask

    task automatic wait_ack(input int budget);
        int n = 0;
        while (!imem_ack && n < budget) begin
            step();
            n++;
        end
        check("wait_ack_timeout", imem_ack, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

        // Reset state
        repeat (2) step();
        mon_en = 1'b1;
        step();
        check("rst_req", imem_req, 1'b0);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_instr", instr, 8'h00);
        check("rst_instr_pc", instr_pc, RESET_PC);
        check("rst_opcode", opcode, 2'b00);

        // First fetch with a 1-cycle memory
        force_dly = 1;
        rst_n = 1'b1;
        check("idle_no_req", imem_req, 1'b0);
        step();
        check("first_req", imem_req, 1'b1);
        check("first_addr", imem_addr, 8'h10);
        wait_ack(10);
        check("valid_before_ack_edge", instr_valid, 1'b0);
        step();
        check("first_valid", instr_valid, 1'b1);
        check("first_instr_pc", instr_pc, 8'h10);
        check("first_instr", instr, mem[8'h10]);

        // Back-pressure for 5 cycles
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_instr_pc", instr_pc, 8'h10);
            check("stall_instr", instr, mem[8'h10]);
            check("stall_no_req", imem_req, 1'b0);
        end
        force_dly = 3;
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        check("next_req", imem_req, 1'b1);
        check("next_addr", imem_addr, 8'h11);

        // Redirect to 0x40 while the request is in flight (ack 3 cycles later)
        redirect = 1'b1;
        redirect_pc = 8'h40;
        step();
        redirect = 1'b0;
        check("discard_req", imem_req, 1'b1);
        check("discard_addr_kept", imem_addr, 8'h11);
        wait_ack(10);
        step();
        check("after_discard_req", imem_req, 1'b1);
        check("after_discard_addr", imem_addr, 8'h40);
        check("stale_not_shown", instr_valid, 1'b0);
        wait_valid(20);
        check("redir_instr_pc", instr_pc, 8'h40);

        // Redirect in the same cycle as ack
        force_dly = 1;
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        check("seq_addr_41", imem_addr, 8'h41);
        wait_ack(10);
        redirect = 1'b1;
        redirect_pc = 8'h80;
        step();
        redirect = 1'b0;
        check("ack_redir_addr", imem_addr, 8'h80);
        check("ack_redir_dropped", instr_valid, 1'b0);
        wait_valid(20);
        check("ack_redir_instr_pc", instr_pc, 8'h80);

        // Redirect in the same cycle as a HOLD handshake
        instr_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 8'hC0;
        step();
        instr_ready = 1'b0;
        redirect = 1'b0;
        check("hs_redir_addr", imem_addr, 8'hC0);
        wait_valid(20);
        check("hs_redir_instr_pc", instr_pc, 8'hC0);

        // PC wrap from 0xFF to 0x00
        redirect = 1'b1;
        redirect_pc = 8'hFF;
        step();
        redirect = 1'b0;
        check("wrap_fetch_ff", imem_addr, 8'hFF);
        wait_valid(20);
        check("wrap_instr_pc", instr_pc, 8'hFF);
        force_dly = 3;
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        check("wrap_req", imem_req, 1'b1);
        check("wrap_addr", imem_addr, 8'h00);

        // Reset while discarding; the stale ack lands in IDLE
        redirect = 1'b1;
        redirect_pc = 8'h55;
        step();
        redirect = 1'b0;
        check("pre_rst_discard_addr", imem_addr, 8'h00);
        rst_n = 1'b0;
        step();
        check("rst_drop_req", imem_req, 1'b0);
        check("rst_addr2", imem_addr, RESET_PC);
`ifdef IFETCH_PERF_EN
        check("rst_perf_fetch", perf_fetch_cnt, 16'd0);
        check("rst_perf_stall", perf_stall_cnt, 16'd0);
`endif
        step();
        check("stale_ack_in_idle", imem_ack, 1'b1);
        rst_n = 1'b1;
        step();
        check("restart_req", imem_req, 1'b1);
        check("restart_addr", imem_addr, RESET_PC);
        check("restart_no_stale", instr_valid, 1'b0);
        wait_valid(20);
        check("restart_instr_pc", instr_pc, RESET_PC);
        check("restart_instr", instr, mem[RESET_PC]);

        // Randomized traffic
        force_dly = 0;
        for (int i = 0; i < 3000; i++) begin
            instr_ready = ($urandom_range(0, 99) < 70);
            redirect    = ($urandom_range(0, 99) < 6);
            redirect_pc = 8'($urandom);
            rst_n       = !(instr_valid && $urandom_range(0, 199) == 0);
            step();
        end
        rst_n = 1'b1;
        redirect = 1'b0;
        instr_ready = 1'b0;
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_instr_fetch_unit
`default_nettype wire
